// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider for DIV/DIVU, returns {remainder, quotient}.
// Define DIV_ANNUL_EN to let annul_i abort or block a division.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                Rst_n,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, DONE} state_t;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [2*DATA_W:0]   dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                s1_q, s1_d, s2_q, s2_d, signed_q, signed_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;
    logic                annul;
    logic [DATA_W:0]     t;
    logic [DATA_W-1:0]   abs1, abs2, q_fix, r_fix;

`ifdef DIV_ANNUL_EN
    assign annul = annul_i;
`else
    assign annul = annul_i & 1'b0;
`endif

    assign t     = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    assign abs1  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // quotient takes the sign of s1^s2, remainder the sign of the dividend
    assign q_fix = (signed_q && (s1_q ^ s2_q)) ? -dividend_q[DATA_W-1:0] : dividend_q[DATA_W-1:0];
    assign r_fix = (signed_q && s1_q) ? -dividend_q[2*DATA_W:DATA_W+1] : dividend_q[2*DATA_W:DATA_W+1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        signed_d   = signed_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul) begin
                    signed_d   = signed_div_i;
                    s1_d       = opdata1_i[DATA_W-1];
                    s2_d       = opdata2_i[DATA_W-1];
                    dividend_d = {{DATA_W{1'b0}}, abs1, 1'b0};
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = '0;
                        divisor_d = abs2;
                    end
                end
            end
            BYZERO: begin
                if (annul) begin
                    state_d    = FREE;
                    cnt_d      = '0;
                    dividend_d = '0;
                end else begin
                    state_d  = DONE;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (annul) begin
                    state_d    = FREE;
                    cnt_d      = '0;
                    dividend_d = '0;
                end else if (cnt_q != 6'd32) begin
                    dividend_d = t[DATA_W] ? {dividend_q[2*DATA_W-1:0], 1'b0}
                                           : {t[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
                    cnt_d      = cnt_q + 6'd1;
                end else begin
                    state_d  = DONE;
                    result_d = {r_fix, q_fix};
                    ready_d  = 1'b1;
                end
            end
            DONE: begin
                if (!start_i || annul) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            signed_q   <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            signed_q   <= signed_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
endmodule
